time_uart_reporter: RTL

TIME_UART_REPORTER -- requirements
Module: time_uart_reporter

---
 rtl/time_uart_reporter_pkg.sv | 30 +++
 rtl/time_uart_reporter_bin2bcd.sv | 20 ++
 rtl/time_uart_reporter.sv | 100 ++++++++++
 3 files changed

// File: rtl/time_uart_reporter_pkg.sv
// Shared constants, types and helpers for the time-of-day UART frame reporter.
// Holds ASCII codes, frame lengths, FSM encoding and the snapshot record.
package time_uart_reporter_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int unsigned FRAME_LEN_CRLF   = 13;
    localparam int unsigned FRAME_LEN_NOCRLF = 11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    typedef struct packed {
        logic [6:0] msec;
        logic [5:0] sec;
        logic [5:0] min;
        logic [4:0] hour;
    } time_snap_t;

    function automatic logic [7:0] ascii_digit(input logic [3:0] digit);
        return ASCII_ZERO + {4'h0, digit};
    endfunction

endpackage

// File: rtl/time_uart_reporter_bin2bcd.sv
// 7-bit binary to two BCD digits, saturating every value above 99 to "99".
// Purely combinational; one instance per time field.
module bin2bcd_sat99 (
    input  logic [6:0] bin_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o
);

    always_comb begin
        // NOTE: both outputs are assigned on every path so no latch is inferred.
        if (bin_i > 7'd99) begin
            tens_o = 4'd9;
            ones_o = 4'd9;
        end else begin
            tens_o = 4'(bin_i / 7'd10);
            ones_o = 4'(bin_i % 7'd10);
        end
    end

endmodule

// File: rtl/time_uart_reporter.sv
// Snapshots HH:MM:SS.CC on request and pushes it as ASCII into a TX FIFO,
// one byte per non-full cycle, optionally terminated with CR LF.
module time_uart_reporter
    import time_uart_reporter_pkg::*;
#(
    parameter bit SEND_CRLF = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] i_msec,
    input  logic [5:0] i_sec,
    input  logic [5:0] i_min,
    input  logic [4:0] i_hour,
    input  logic       i_req,
    input  logic       i_fifo_full,
    output logic       o_push,
    output logic [7:0] o_data,
    output logic       o_busy
);

    localparam logic [3:0] LAST_IDX =
        4'(SEND_CRLF ? FRAME_LEN_CRLF - 1 : FRAME_LEN_NOCRLF - 1);

    state_e     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    time_snap_t snap_q, snap_d;

    logic       push;
    logic [7:0] byte_sel;
    logic [3:0] hour_t, hour_o, min_t, min_o, sec_t, sec_o, cs_t, cs_o;

    bin2bcd_sat99 u_bcd_hour (.bin_i({2'b00, snap_q.hour}), .tens_o(hour_t), .ones_o(hour_o));
    bin2bcd_sat99 u_bcd_min  (.bin_i({1'b0,  snap_q.min}),  .tens_o(min_t),  .ones_o(min_o));
    bin2bcd_sat99 u_bcd_sec  (.bin_i({1'b0,  snap_q.sec}),  .tens_o(sec_t),  .ones_o(sec_o));
    bin2bcd_sat99 u_bcd_cs   (.bin_i(snap_q.msec),          .tens_o(cs_t),   .ones_o(cs_o));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req) begin
                    snap_d  = '{msec: i_msec, sec: i_sec, min: i_min, hour: i_hour};
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                // Requests arriving here, even on the final push, are dropped.
                if (push) begin
                    if (idx_q == LAST_IDX) state_d = ST_IDLE;
                    else                   idx_d   = idx_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        case (idx_q)
            4'd0:    byte_sel = ascii_digit(hour_t);
            4'd1:    byte_sel = ascii_digit(hour_o);
            4'd2:    byte_sel = ASCII_COLON;
            4'd3:    byte_sel = ascii_digit(min_t);
            4'd4:    byte_sel = ascii_digit(min_o);
            4'd5:    byte_sel = ASCII_COLON;
            4'd6:    byte_sel = ascii_digit(sec_t);
            4'd7:    byte_sel = ascii_digit(sec_o);
            4'd8:    byte_sel = ASCII_DOT;
            4'd9:    byte_sel = ascii_digit(cs_t);
            4'd10:   byte_sel = ascii_digit(cs_o);
            4'd11:   byte_sel = ASCII_CR;
            4'd12:   byte_sel = ASCII_LF;
            default: byte_sel = 8'h00;
        endcase
    end

    always_comb begin
        push   = (state_q == ST_SEND) && !i_fifo_full;
        o_push = push;
        o_busy = (state_q == ST_SEND);
        o_data = push ? byte_sel : 8'h00;
    end

endmodule
